// File: rtl/sorted_stream_reader.sv
// Drains a sorted sample buffer from RAM addresses 0..numSamples-1 into a valid/ready stream.
// Optional ordering monitor enabled by defining SORTED_STREAM_ORDER_CHECK_EN.
module sorted_stream_reader #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH:0]   numSamples,
  output logic                      rdEn,
  output logic [MEM_ADDR_WIDTH-1:0] rdAddr,
  input  logic [DATA_WIDTH-1:0]     rdData,
  output logic [DATA_WIDTH-1:0]     outData,
  output logic                      outValid,
  input  logic                      outReady,
  output logic                      outLast,
  output logic                      busy,
  output logic                      done,
  output logic                      orderError
);

  localparam int AW    = MEM_ADDR_WIDTH;
  localparam int CW    = MEM_ADDR_WIDTH + 1;
  localparam int DEPTH = 3;
  localparam logic [CW-1:0] MAX_N = CW'(1) << AW;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                             state_q, state_d;
  logic [1:0]                         vld_pipe;  // [0] read issued this cycle, [1] rdData valid this cycle
  logic [DEPTH-1:0][DATA_WIDTH-1:0]   buf_q, buf_d;
  logic [1:0]                         occ_q, occ_d, wr_idx;
  logic [CW-1:0]                      num_q, issue_q, issue_d, sent_q, sent_d;
  logic [AW-1:0]                      addr_q, addr_d;
  logic                               valid_q, last_q, last_d, busy_q, done_q;
  logic                               start_ok, push, pop, last_hs, issue, space;

  assign start_ok = start && (numSamples != '0) && (numSamples <= MAX_N);
  assign push     = vld_pipe[1];
  assign pop      = valid_q && outReady;
  assign last_hs  = pop && last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)           state_d = READ;
      READ:    if (issue_q == num_q)   state_d = DRAIN;
      DRAIN:   if (last_hs)            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d  = occ_q + 2'(push) - 2'(pop);
    wr_idx = occ_q - 2'(pop);
    buf_d  = buf_q;
    if (pop)
      for (int i = 0; i < DEPTH-1; i++) buf_d[i] = buf_q[i+1];
    if (push)
      for (int i = 0; i < DEPTH; i++)
        if (wr_idx == 2'(i)) buf_d[i] = rdData;

    // Reserve a slot for every read already issued so the buffer cannot overflow.
    space   = (3'(occ_d) + 3'(vld_pipe[0])) < 3'(DEPTH);
    issue   = 1'b0;
    addr_d  = addr_q;
    issue_d = issue_q;
    sent_d  = pop ? sent_q + CW'(1) : sent_q;
    case (state_q)
      IDLE: if (start_ok) begin
        issue   = 1'b1;
        addr_d  = '0;
        issue_d = CW'(1);
        sent_d  = '0;
      end
      READ: if ((issue_q != num_q) && space) begin
        issue   = 1'b1;
        addr_d  = issue_q[AW-1:0];
        issue_d = issue_q + CW'(1);
      end
      default: ;
    endcase
    last_d = (occ_d != 2'd0) && (sent_d == num_q - CW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      buf_q    <= '0;
      occ_q    <= '0;
      num_q    <= '0;
      issue_q  <= '0;
      sent_q   <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], issue};
      buf_q    <= buf_d;
      occ_q    <= occ_d;
      if (state_q == IDLE && start_ok) num_q <= numSamples;
      issue_q  <= issue_d;
      sent_q   <= sent_d;
      addr_q   <= addr_d;
      valid_q  <= occ_d != 2'd0;
      last_q   <= last_d;
      busy_q   <= state_d != IDLE;
      done_q   <= (state_q == DRAIN) && last_hs;
    end
  end

  assign rdEn     = vld_pipe[0];
  assign rdAddr   = addr_q;
  assign outData  = buf_q[0];
  assign outValid = valid_q;
  assign outLast  = last_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef SORTED_STREAM_ORDER_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_q;
  logic                  have_prev_q, err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (state_q == IDLE && start_ok) begin
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (pop) begin
      if (have_prev_q && (buf_q[0] < prev_q)) err_q <= 1'b1;
      prev_q      <= buf_q[0];
      have_prev_q <= 1'b1;
    end
  end

  assign orderError = err_q;
`else
  assign orderError = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_stream_reader.sv
// Directed bench for sorted_stream_reader: RAM model, expected-sample queue, latency and reset checks.
module tb_sorted_stream_reader;

  logic        clk = 1'b0;
  logic        rst, start, outReady;
  logic [16:0] numSamples;
  logic        rdEn;
  logic [15:0] rdAddr;
  logic [31:0] rdData = '0;
  logic [31:0] outData;
  logic        outValid, outLast, busy, done, orderError;

  sorted_stream_reader #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .numSamples(numSamples),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData),
    .outData(outData), .outValid(outValid), .outReady(outReady), .outLast(outLast),
    .busy(busy), .done(done), .orderError(orderError)
  );

  always #5 clk = ~clk;

`ifdef SORTED_STREAM_ORDER_CHECK_EN
  localparam logic ORD = 1'b1;
`else
  localparam logic ORD = 1'b0;
`endif

  logic [31:0] mem [0:65535];
  always @(posedge clk) if (rdEn) rdData <= mem[rdAddr];

  typedef struct packed { logic [31:0] d; logic last; } item_t;
  item_t sb[$];

  int tests = 0, fails = 0;
  int issued = 0, hs_cnt = 0, max_out = 0, seq_err = 0;
  logic [16:0] exp_addr = '0;
  logic [15:0] last_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({rdEn, rdAddr, outData, outValid, outLast, busy, done, orderError});
  endfunction

  // Read-side and stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rdEn) begin
        if (17'(rdAddr) !== exp_addr) seq_err++;
        exp_addr++;
        last_addr = rdAddr;
        issued++;
      end
      if (issued - hs_cnt > max_out) max_out = issued - hs_cnt;
      if (outValid && outReady) begin
        item_t e;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk("stream_item", 64'({outData, outLast}), 64'({e.d, e.last}));
        hs_cnt++;
      end
    end
  end

  task automatic do_start(input int n);
    @(posedge clk); #1;
    issued = 0; hs_cnt = 0; max_out = 0; seq_err = 0; exp_addr = '0;
    for (int i = 0; i < n; i++) sb.push_back('{d: mem[i], last: (i == n-1)});
    start = 1'b1;
    numSamples = 17'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit rnd, output int cyc, output int fv);
    cyc = 1;
    fv  = outValid ? 1 : -1;
    while (!done && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      if (outValid && fv < 0) fv = cyc;
      if (rnd) outReady = 1'($urandom_range(0, 1));
    end
    outReady = 1'b1;
  endtask

  task automatic ignored_start(input logic [16:0] n);
    @(posedge clk); #1;
    start = 1'b1; numSamples = n;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignored_busy", 64'(busy), 64'd0);
    chk("ignored_rden", 64'(rdEn), 64'd0);
  endtask

  initial begin
    int cyc, fv, guard;
    rst = 1'b1; start = 1'b0; numSamples = '0; outReady = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i) << 4;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 64'd0);
    rst = 1'b0;

    // Single sample
    mem[0] = 32'h5;
    do_start(1);
    chk("n1_busy", 64'(busy), 64'd1);
    chk("n1_rden", 64'({rdEn, rdAddr}), 64'({1'b1, 16'h0}));
    wait_done(50, 1'b0, cyc, fv);
    chk("n1_first_valid", 64'(fv), 64'd3);
    chk("n1_done_latency", 64'(cyc), 64'd4);
    chk("n1_busy_at_done", 64'(busy), 64'd0);
    chk("n1_hs", 64'(hs_cnt), 64'd1);
    @(posedge clk); #1;
    chk("n1_done_pulse", 64'(done), 64'd0);

    // Eight samples, full throughput
    for (int i = 0; i < 8; i++) mem[i] = 32'(i);
    do_start(8);
    wait_done(100, 1'b0, cyc, fv);
    chk("n8_first_valid", 64'(fv), 64'd3);
    chk("n8_done_latency", 64'(cyc), 64'd11);
    chk("n8_hs", 64'(hs_cnt), 64'd8);
    chk("n8_sb_empty", 64'(sb.size()), 64'd0);

    // Sixteen samples under random backpressure
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    do_start(16);
    wait_done(2000, 1'b1, cyc, fv);
    chk("n16_done_seen", 64'(done), 64'd1);
    chk("n16_hs", 64'(hs_cnt), 64'd16);
    chk("n16_sb_empty", 64'(sb.size()), 64'd0);
    chk("n16_outstanding_le3", 64'(max_out <= 3), 64'd1);
    chk("n16_addr_seq", 64'(seq_err), 64'd0);

    // Ordering monitor: equal neighbours legal, a decrease flagged
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd2; mem[3] = 32'd1;
    do_start(3);
    wait_done(100, 1'b0, cyc, fv);
    chk("ord_equal_ok", 64'(orderError), 64'd0);
    do_start(4);
    wait_done(100, 1'b0, cyc, fv);
    chk("ord_error_set", 64'(orderError), 64'(ORD));
    @(posedge clk); #1;
    chk("ord_error_sticky", 64'(orderError), 64'(ORD));
    do_start(1);
    chk("ord_error_cleared", 64'(orderError), 64'd0);
    wait_done(50, 1'b0, cyc, fv);

    // Reset in the middle of a 20-sample drain
    for (int i = 0; i < 20; i++) mem[i] = 32'h100 + 32'(i);
    do_start(20);
    guard = 0;
    while (hs_cnt < 5 && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("mid_reached_5", 64'(hs_cnt >= 5), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_reset_outputs", outs(), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);
    do_start(4);
    wait_done(100, 1'b0, cyc, fv);
    chk("post_reset_latency", 64'(cyc), 64'd7);
    chk("post_reset_hs", 64'(hs_cnt), 64'd4);
    chk("post_reset_sb_empty", 64'(sb.size()), 64'd0);

    // Illegal counts are ignored
    ignored_start(17'd0);
    ignored_start(17'd65537);
    @(posedge clk); #1;
    chk("ignored_still_idle", 64'(busy), 64'd0);

    // Full address range
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i) << 4;
    do_start(65536);
    wait_done(65536 + 50, 1'b0, cyc, fv);
    chk("full_done_latency", 64'(cyc), 64'd65539);
    chk("full_hs", 64'(hs_cnt), 64'd65536);
    chk("full_issued", 64'(issued), 64'd65536);
    chk("full_last_addr", 64'(last_addr), 64'hFFFF);
    chk("full_addr_seq", 64'(seq_err), 64'd0);
    chk("full_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
